// File: rtl/iomem_arb_pkg.sv
// -----------------------------------------------------------------------------
// iomem_arb_pkg
// Shared definitions for the two-master iomem arbiter: FSM state encoding,
// default watchdog length and timeout read data, and the master index type.
// -----------------------------------------------------------------------------
package iomem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int          IOMEM_ARB_DEFAULT_TIMEOUT = 1024;
    localparam logic [31:0] IOMEM_ARB_TIMEOUT_RDATA   = 32'hDEAD_BEEF;
    localparam int          IOMEM_ARB_MIDX_W          = 1;

    typedef logic [IOMEM_ARB_MIDX_W-1:0] midx_t;

endpackage

// File: rtl/iomem_arbiter_if.sv
// -----------------------------------------------------------------------------
// iomem_arbiter_if
// One picorv32-style iomem bus (valid/ready handshake).
//   master modport : drives valid/wstrb/addr/wdata, receives ready/rdata
//   slave  modport : receives valid/wstrb/addr/wdata, drives ready/rdata
// wstrb == 0 denotes a read.
// -----------------------------------------------------------------------------
interface iomem_arbiter_if;

    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
    modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);

endinterface

// File: rtl/iomem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// iomem_timeout_ctr
// Watchdog counter for a single outstanding slave access.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   clear_i     : force count to 0 (held while no access is outstanding)
//   enable_i    : advance count by one this cycle
//   expire_o    : count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module iomem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == LAST);

    // Holds at LAST rather than wrapping; the arbiter leaves BUSY on expiry anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iomem_arbiter.sv
// -----------------------------------------------------------------------------
// iomem_arbiter
// Shares one PicoSoC iomem peripheral bus between two masters
// (m0 = CPU iomem port, m1 = debug/VIO bus master), round-robin per access.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   m0, m1       : master-side buses (arbiter acts as their slave)
//   s            : shared slave bus (arbiter acts as its master)
//   timeout_irq  : one-cycle pulse per watchdog-completed access
// Build option:
//   IOMEM_ARB_TIMEOUT_EN  when defined, a watchdog completes a hung access
//                         after TIMEOUT_CYCLES BUSY cycles with TIMEOUT_RDATA.
//                         Otherwise BUSY waits indefinitely and timeout_irq=0.
//
// state | meaning
// IDLE  | no access; pick owner from pending requests (one cycle)
// BUSY  | owner's request forwarded to slave, waiting on s.ready
// DONE  | one quiet cycle so the owner can drop valid before re-arbitration
// -----------------------------------------------------------------------------
module iomem_arbiter
    import iomem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = IOMEM_ARB_DEFAULT_TIMEOUT,
    parameter logic [31:0] TIMEOUT_RDATA  = IOMEM_ARB_TIMEOUT_RDATA
) (
    input  logic            clk,
    input  logic            reset,
    iomem_arbiter_if.slave  m0,
    iomem_arbiter_if.slave  m1,
    iomem_arbiter_if.master s,
    output logic            timeout_irq
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("iomem_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    arb_state_e  state_q, state_d;
    midx_t       owner_q, owner_d;
    midx_t       last_grant_q, last_grant_d;

    logic        busy;
    logic        sel_m1;
    logic        owner_valid;
    logic        expire;
    logic        to_fire;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    assign busy   = (state_q == ST_BUSY);
    assign sel_m1 = (owner_q == midx_t'(1));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        owner_valid  = sel_m1 ? m1.valid : m0.valid;
        to_fire      = 1'b0;
        rsp_ready    = 1'b0;
        rsp_rdata    = '0;
        s.valid      = 1'b0;
        s.wstrb      = '0;
        s.addr       = '0;
        s.wdata      = '0;

        case (state_q)
            ST_IDLE: begin
                if (m0.valid || m1.valid) begin
                    if (m0.valid && m1.valid) begin
                        owner_d = ~last_grant_q;
                    end else begin
                        owner_d = m1.valid ? midx_t'(1) : midx_t'(0);
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A genuine s.ready in the expiry cycle takes precedence.
                to_fire   = owner_valid && !s.ready && expire;
                s.valid   = owner_valid && !to_fire;
                s.wstrb   = sel_m1 ? m1.wstrb : m0.wstrb;
                s.addr    = sel_m1 ? m1.addr  : m0.addr;
                s.wdata   = sel_m1 ? m1.wdata : m0.wdata;
                rsp_ready = (owner_valid && s.ready) || to_fire;
                rsp_rdata = to_fire ? TIMEOUT_RDATA : s.rdata;
                if (rsp_ready) begin
                    last_grant_d = owner_q;
                    state_d      = ST_DONE;
                end else if (!owner_valid) begin
                    // Owner withdrew (e.g. was reset): abandon without touching fairness.
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        m0.ready = rsp_ready && !sel_m1;
        m1.ready = rsp_ready &&  sel_m1;
        m0.rdata = sel_m1 ? '0 : rsp_rdata;
        m1.rdata = sel_m1 ? rsp_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= midx_t'(0);
            last_grant_q <= midx_t'(1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef IOMEM_ARB_TIMEOUT_EN
    iomem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!busy),
        .enable_i (busy && !s.ready),
        .expire_o (expire)
    );
    assign timeout_irq = to_fire;
`else
    assign expire      = 1'b0;
    assign timeout_irq = 1'b0;
`endif

endmodule
